prim_secded_pipe_dec: RTL

Pipelined, parametrised Hsiao SECDED decoder with a valid/ready stream interface, sideband tag, saturating error counters and a first-uncorrectable-error log. It generalises the fixed 72/64 combinational decoder to any `DataWidth`/`ParityWidth` pair. It sits between memory read ports (RAM, ICache data/tag arrays) and their consumers. Unlike the combinational decoder, it classifies unmatched odd syndromes as uncorrectable.

---
 rtl/prim_secded_pkg.sv | 45 ++++
 rtl/prim_secded_err_log.sv | 80 ++++++++
 rtl/prim_secded_pipe_dec.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/prim_secded_pkg.sv
// Shared types and Hsiao H-matrix helpers for the pipelined SECDED decoder.
// Columns are generated here so no per-bit parity equations appear anywhere.
package prim_secded_pkg;

    typedef enum logic [1:0] {
        SECDED_NONE   = 2'b00,
        SECDED_CORR   = 2'b01,
        SECDED_UNCORR = 2'b10
    } secded_err_e;

    function automatic int unsigned popcnt(int unsigned value);
        int unsigned v;
        int unsigned n;
        v = value;
        n = 0;
        while (v != 0) begin
            v = v & (v - 1);
            n++;
        end
        return n;
    endfunction

    // Column j: the j-th odd-weight (>=3) value, ordered by weight then by value.
    function automatic int unsigned hsiao_col(int unsigned pw, int unsigned j);
        int unsigned idx;
        int unsigned col;
        idx = 0;
        col = 0;
        for (int unsigned w = 3; w <= pw; w += 2) begin
            for (int unsigned v = 0; v < (32'd1 << pw); v++) begin
                if (popcnt(v) == w) begin
                    if (idx == j) col = v;
                    idx++;
                end
            end
        end
        return col;
    endfunction

    // Number of odd-weight (>=3) columns available: 2^(pw-1) - pw.
    function automatic int unsigned hsiao_max_data(int unsigned pw);
        return (32'd1 << (pw - 1)) - pw;
    endfunction

endpackage

// File: rtl/prim_secded_err_log.sv
// Saturating corrected/uncorrectable word counters plus a sticky log of the
// first uncorrectable word since the last clear.
module prim_secded_err_log
    import prim_secded_pkg::*;
#(
    parameter int unsigned ParityWidth = 8,
    parameter int unsigned TagWidth    = 4,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   hs_i,
    input  logic [1:0]             err_i,
    input  logic [ParityWidth-1:0] syndrome_i,
    input  logic [TagWidth-1:0]    tag_i,
    input  logic                   clr_i,
    output logic [CntWidth-1:0]    corr_cnt_o,
    output logic [CntWidth-1:0]    uncorr_cnt_o,
    output logic                   log_valid_o,
    output logic [TagWidth-1:0]    log_tag_o,
    output logic [ParityWidth-1:0] log_syndrome_o
);

    logic [CntWidth-1:0]    corr_cnt_d, corr_cnt_q;
    logic [CntWidth-1:0]    uncorr_cnt_d, uncorr_cnt_q;
    logic                   log_valid_d, log_valid_q;
    logic [TagWidth-1:0]    log_tag_d, log_tag_q;
    logic [ParityWidth-1:0] log_syn_d, log_syn_q;

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        log_valid_d  = log_valid_q;
        log_tag_d    = log_tag_q;
        log_syn_d    = log_syn_q;
        // Clear has priority: a same-cycle increment or capture is dropped.
        if (clr_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
            log_valid_d  = 1'b0;
            log_tag_d    = '0;
            log_syn_d    = '0;
        end else if (hs_i) begin
            if (err_i == SECDED_CORR && corr_cnt_q != '1) begin
                corr_cnt_d = corr_cnt_q + CntWidth'(1);
            end
            if (err_i == SECDED_UNCORR) begin
                if (uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CntWidth'(1);
                if (!log_valid_q) begin
                    log_valid_d = 1'b1;
                    log_tag_d   = tag_i;
                    log_syn_d   = syndrome_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            log_valid_q  <= 1'b0;
            log_tag_q    <= '0;
            log_syn_q    <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            log_valid_q  <= log_valid_d;
            log_tag_q    <= log_tag_d;
            log_syn_q    <= log_syn_d;
        end
    end

    assign corr_cnt_o     = corr_cnt_q;
    assign uncorr_cnt_o   = uncorr_cnt_q;
    assign log_valid_o    = log_valid_q;
    assign log_tag_o      = log_tag_q;
    assign log_syndrome_o = log_syn_q;

endmodule

// File: rtl/prim_secded_pipe_dec.sv
// Two-stage Hsiao SECDED decoder with valid/ready stream and sideband tag.
// Counters and error log exist only when PRIM_SECDED_ERR_LOG_EN is defined.
module prim_secded_pipe_dec
    import prim_secded_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned ParityWidth = 8,
    parameter int unsigned TagWidth    = 4,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [DataWidth+ParityWidth-1:0] in_i,
    input  logic [TagWidth-1:0]              tag_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [DataWidth-1:0]             d_o,
    output logic [ParityWidth-1:0]           syndrome_o,
    output logic [1:0]                       err_o,
    output logic [TagWidth-1:0]              tag_o,
    input  logic                             cnt_clr_i,
    output logic [CntWidth-1:0]              corr_cnt_o,
    output logic [CntWidth-1:0]              uncorr_cnt_o,
    output logic                             log_valid_o,
    output logic [TagWidth-1:0]              log_tag_o,
    output logic [ParityWidth-1:0]           log_syndrome_o
);

    localparam int unsigned CodeWidth = DataWidth + ParityWidth;

    if (DataWidth > hsiao_max_data(ParityWidth)) begin : g_bad_width
        $error("ParityWidth too small for DataWidth odd-weight columns");
    end

    logic [ParityWidth-1:0] col_tab [DataWidth];
    for (genvar j = 0; j < DataWidth; j++) begin : g_col
        localparam int unsigned ColVal = hsiao_col(ParityWidth, j);
        assign col_tab[j] = ColVal[ParityWidth-1:0];
    end

    logic s1_adv, s2_adv;

    logic                   s1_valid_d, s1_valid_q;
    logic [DataWidth-1:0]   s1_data_d, s1_data_q;
    logic [TagWidth-1:0]    s1_tag_d, s1_tag_q;
    logic [ParityWidth-1:0] s1_syn_d, s1_syn_q;

    logic                   s2_valid_d, s2_valid_q;
    logic [DataWidth-1:0]   s2_data_d, s2_data_q;
    logic [TagWidth-1:0]    s2_tag_d, s2_tag_q;
    logic [ParityWidth-1:0] s2_syn_d, s2_syn_q;
    secded_err_e            s2_err_d, s2_err_q;

    logic [ParityWidth-1:0] in_syn;
    logic [DataWidth-1:0]   flip;
    logic [DataWidth-1:0]   s1_data_corr;
    secded_err_e            s1_err;

    assign s2_adv  = !s2_valid_q | ready_i;
    assign s1_adv  = !s1_valid_q | s2_adv;
    assign ready_o = s1_adv;

    // NOTE: blocking assignments accumulate the XOR inside one combinational pass.
    always_comb begin
        in_syn = '0;
        for (int j = 0; j < DataWidth; j++) begin
            if (in_i[j]) in_syn = in_syn ^ col_tab[j];
        end
        // Check-bit columns are one-hot, so check bits fold in directly.
        in_syn = in_syn ^ in_i[CodeWidth-1:DataWidth];
    end

    always_comb begin
        flip = '0;
        for (int j = 0; j < DataWidth; j++) begin
            flip[j] = (s1_syn_q == col_tab[j]);
        end
        s1_err = SECDED_UNCORR;
        if (s1_syn_q == '0) begin
            s1_err = SECDED_NONE;
        end else if ($onehot(s1_syn_q) || (|flip)) begin
            s1_err = SECDED_CORR;
        end
        s1_data_corr = s1_data_q ^ flip;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s1_syn_d   = s1_syn_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_syn_d   = s2_syn_q;
        s2_err_d   = s2_err_q;
        if (s1_adv) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_data_d = in_i[DataWidth-1:0];
                s1_tag_d  = tag_i;
                s1_syn_d  = in_syn;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_corr;
                s2_tag_d  = s1_tag_q;
                s2_syn_d  = s1_syn_q;
                s2_err_d  = s1_err;
            end
        end
    end

    // NOTE: datapath flops are reset as well so outputs read as zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_syn_q   <= '0;
            s2_err_q   <= SECDED_NONE;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
            s2_syn_q   <= s2_syn_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign valid_o    = s2_valid_q;
    assign d_o        = s2_data_q;
    assign syndrome_o = s2_syn_q;
    assign err_o      = s2_err_q;
    assign tag_o      = s2_tag_q;

`ifdef PRIM_SECDED_ERR_LOG_EN
    prim_secded_err_log #(
        .ParityWidth (ParityWidth),
        .TagWidth    (TagWidth),
        .CntWidth    (CntWidth)
    ) u_err_log (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .hs_i           (s2_valid_q & ready_i),
        .err_i          (s2_err_q),
        .syndrome_i     (s2_syn_q),
        .tag_i          (s2_tag_q),
        .clr_i          (cnt_clr_i),
        .corr_cnt_o     (corr_cnt_o),
        .uncorr_cnt_o   (uncorr_cnt_o),
        .log_valid_o    (log_valid_o),
        .log_tag_o      (log_tag_o),
        .log_syndrome_o (log_syndrome_o)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign corr_cnt_o     = '0;
    assign uncorr_cnt_o   = '0;
    assign log_valid_o    = 1'b0;
    assign log_tag_o      = '0;
    assign log_syndrome_o = '0;
`endif

endmodule
